imm_decode_sequencer: RTL
=========================

// Module: imm_decode_sequencer
// PURPOSE
//  Decode-stage sequencer for the SignExtend immediate unit. Accepts fetched instructions over a
//  valid/ready handshake and derives ImmSrc from the opcode. Drives one internal SignExtend
//  instance and registers {Instr, ImmSrc, ImmExt, ImmType} into a 2-entry skid buffer feeding
//  execute. Supports flush and back-pressure, and flags opcodes that carry no immediate.
// PARAMETERS
//  XLEN     32  datapath width; only 32 is supported (elaboration error otherwise)
//  CNT_W    16  width of the optional stall counter
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     asynchronous, active-low reset
//  InstrValid   in   1     fetch presents Instr
//  InstrReady   out  1     sequencer can accept Instr this cycle
//  Instr        in   32    raw instruction word
//  Flush        in   1     discard all buffered entries (branch redirect)
//  ImmValid     out  1     head entry valid toward execute
//  ImmReady     in   1     execute consumes head entry
//  InstrOut     out  32    instruction of head entry
//  ImmSrcOut    out  2     ImmSrc used for head entry
//  ImmExtOut    out  32    extended immediate of head entry
//  NoImm        out  1     head opcode is R-type/unknown; ImmExtOut is 0
//  StallCnt     out  CNT_W cycles with ImmValid&&!ImmReady (IMM_STALL_CNT_EN only)
// BEHAVIOUR
//  - Opcode map (Instr[6:0]) -> ImmSrc:
//      1101111 JAL, 0110111 LUI, 0010111 AUIPC  -> 00
//      0010011 OP-IMM, 0000011 LOAD, 1100111 JALR -> 01
//      1100011 BRANCH -> 10;  0100011 STORE -> 11
//      all others -> ImmSrc=01, NoImm=1, stored ImmExt forced to 0
//  - Extension is combinational from Instr; the result is captured on accept (accept = InstrValid && InstrReady).
//  - Latency: accepted in cycle N -> ImmValid=1 in cycle N+1. Throughput is 1/cycle with ImmReady high.
//  - Buffer FSM states: EMPTY(0), ONE(1), TWO(2). InstrReady = (state != TWO), which is registered.
//      EMPTY: accept -> ONE
//      ONE:   accept & pop -> ONE; accept only -> TWO; pop only -> EMPTY
//      TWO:   pop -> ONE (no accept possible)
//    pop = ImmValid && ImmReady. Entries leave in FIFO order; the head is always slot 0.
//  - Simultaneous accept+pop in ONE: the new entry becomes the head next cycle, with no bubble.
//  - Flush: the next state is EMPTY, and any accept in the same cycle is dropped.
//    ImmValid=0 in the following cycle. Flush has priority over accept and pop.
//  - Output data is held stable while ImmValid && !ImmReady. It is don't-care when ImmValid=0,
//    but the implementation holds the last value.
//  - Reset (async assert, sync deassert assumed upstream): state=EMPTY, ImmValid=0,
//    InstrReady=1 after release, InstrOut=0, ImmSrcOut=00, ImmExtOut=0, NoImm=0, StallCnt=0.
//    Reset mid-transfer drops all buffered entries.
//  - Instr may change while InstrValid=1 && InstrReady=0. It is sampled only on accept.
// CONFIGURATION
//  - `IMM_STALL_CNT_EN defined:
//      StallCnt increments each cycle ImmValid && !ImmReady, and saturates at all-ones.
//      It is cleared only by reset; Flush does not clear it.
//  - Not defined: StallCnt is tied to 0 and no counter flops are inferred.
// TESTING
//  - Reset: hold rst=0 with random Instr. All outputs are 0 and InstrReady=1 one cycle after release.
//  - I-type: Instr=32'hFFF00093 (addi x1,x0,-1), ImmReady=1
//      -> next cycle ImmValid=1, ImmSrcOut=01, ImmExtOut=32'hFFFFFFFF.
//  - S then B back-to-back:
//      32'hFE112E23 -> ImmSrcOut=11, ImmExtOut=32'hFFFFFFFC
//      32'hFE000EE3 -> ImmSrcOut=10, ImmExtOut=32'hFFFFFFFC
//      consecutive cycles, no bubble.
//  - Back-pressure: ImmReady=0 with 3 valid instructions
//      -> 2 accepted, InstrReady=0, outputs stable.
//      ImmReady=1 -> drained in order, and the third is accepted the cycle after the first pop.
//  - Flush with state TWO and InstrValid=1 -> next cycle ImmValid=0, InstrReady=1, the new Instr is not seen.
//  - R-type 32'h002081B3 -> NoImm=1, ImmExtOut=0.
//    With IMM_STALL_CNT_EN: 5 stall cycles -> StallCnt=5.

Source files
------------

// File: rtl/imm_decode_sequencer.sv
// Decode-stage immediate sequencer: opcode -> ImmSrc decode, one SignExtend
// instance, and a 2-entry skid buffer toward execute with flush/back-pressure.
// Optional feature macro: IMM_STALL_CNT_EN (enables the saturating stall counter).

// Immediate extension by format; ImmSrc 00 covers both J and U formats,
// told apart by opcode bit 3 (set for JAL, clear for LUI/AUIPC).
module SignExtend (
   input  logic [31:0] Instr,
   input  logic [1:0]  ImmSrc,
   output logic [31:0] ImmExt
);

   // Format-dependent immediate assembly and sign extension
   always_comb begin
      ImmExt = '0;
      case (ImmSrc)
         2'b00: begin
            if (Instr[3]) begin
               ImmExt = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            end else begin
               ImmExt = {Instr[31:12], 12'b0};
            end
         end
         2'b01:   ImmExt = {{20{Instr[31]}}, Instr[31:20]};
         2'b10:   ImmExt = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
         default: ImmExt = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      endcase
   end

endmodule

module imm_decode_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             InstrValid,
   output logic             InstrReady,
   input  logic [XLEN-1:0]  Instr,
   input  logic             Flush,
   output logic             ImmValid,
   input  logic             ImmReady,
   output logic [XLEN-1:0]  InstrOut,
   output logic [1:0]       ImmSrcOut,
   output logic [XLEN-1:0]  ImmExtOut,
   output logic             NoImm,
   output logic [CNT_W-1:0] StallCnt
);

   if (XLEN != 32) begin : g_xlen_check
      $error("imm_decode_sequencer: only XLEN = 32 is supported");
   end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [1:0]      src;
      logic [XLEN-1:0] ext;
      logic            no_imm;
   } entry_t;

   state_t          state_q, state_d;
   entry_t          slot0_q, slot0_d;
   entry_t          slot1_q, slot1_d;
   entry_t          new_entry;
   logic            ready_q, valid_q;
   logic [1:0]      imm_src;
   logic            no_imm;
   logic [XLEN-1:0] imm_ext;
   logic            accept, pop;

   // Opcode decode to ImmSrc; unknown/R-type opcodes flag NoImm
   always_comb begin
      imm_src = 2'b01;
      no_imm  = 1'b0;
      case (Instr[6:0])
         7'b1101111, 7'b0110111, 7'b0010111: imm_src = 2'b00;
         7'b0010011, 7'b0000011, 7'b1100111: imm_src = 2'b01;
         7'b1100011:                         imm_src = 2'b10;
         7'b0100011:                         imm_src = 2'b11;
         default:                            no_imm  = 1'b1;
      endcase
   end

   SignExtend u_sign_extend (
      .Instr  (Instr),
      .ImmSrc (imm_src),
      .ImmExt (imm_ext)
   );

   // Entry captured on accept; ImmExt forced to zero for opcodes without an immediate
   always_comb begin
      new_entry.instr  = Instr;
      new_entry.src    = imm_src;
      new_entry.ext    = no_imm ? '0 : imm_ext;
      new_entry.no_imm = no_imm;
   end

   assign accept = InstrValid && ready_q;
   assign pop    = valid_q && ImmReady;

   // Buffer next-state and slot updates; slot 0 is always the head
   always_comb begin
      state_d = state_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      if (Flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  slot0_d = new_entry;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  slot0_d = new_entry;
               end else if (accept) begin
                  slot1_d = new_entry;
                  state_d = TWO;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  slot0_d = slot1_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State, handshake flags and slot storage; flags are registered from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != TWO);
         valid_q <= (state_d != EMPTY);
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

   assign InstrReady = ready_q;
   assign ImmValid   = valid_q;
   assign InstrOut   = slot0_q.instr;
   assign ImmSrcOut  = slot0_q.src;
   assign ImmExtOut  = slot0_q.ext;
   assign NoImm      = slot0_q.no_imm;

`ifdef IMM_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where execute holds off a valid head
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (valid_q && !ImmReady && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register; cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
`else
   assign StallCnt = '0;
`endif

endmodule
